// File: rtl/uart_tx_serializer.sv
// UART transmitter: one-word holding register feeding a shift-register FSM.
// Bit timing comes from the baud square wave clk_s, edge-detected in the clk_100 domain.
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_100,
    input  logic                 rst_n,
    input  logic                 clk_s,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int STOP_W = $clog2(STOP_BITS + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE    = BIT_W'(1);
    localparam logic [STOP_W-1:0] STOP_LAST  = STOP_W'(STOP_BITS - 1);
    localparam logic [STOP_W-1:0] STOP_ONE   = STOP_W'(1);
    localparam logic              HAS_PARITY = 1'(PARITY != 0);
    localparam logic              ODD_PARITY = 1'(PARITY == 2);

    generate
        if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
            (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_param
            $error("uart_tx_serializer: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_f(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic                  clk_s_d_r;
    logic                  baud_tick_s;
    logic [DATA_BITS-1:0]  hold_r;
    logic                  tx_ready_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic [DATA_BITS-1:0]  shift_nx_s;
    logic                  parity_r;
    logic [BIT_W-1:0]      bit_idx_r;
    logic [BIT_W-1:0]      bit_idx_nx_s;
    logic [STOP_W-1:0]     stop_cnt_r;
    logic [STOP_W-1:0]     stop_cnt_nx_s;
    logic                  tx_r;
    logic                  tx_nx_s;
    logic                  busy_r;
    logic                  load_s;
    logic                  hold_full_s;
    logic                  last_stop_s;

    assign baud_tick_s = clk_s & ~clk_s_d_r;
    assign hold_full_s = ~tx_ready_r;
    assign last_stop_s = (stop_cnt_r == STOP_LAST);

    assign tx_ready = tx_ready_r;
    assign tx       = tx_r;
    assign busy     = busy_r;

    // State register; busy is registered alongside it from the next state.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Next-state logic; every transition waits for a baud tick.
    always_comb begin
        state_nx_s = state_r;
        if (baud_tick_s) begin
            case (state_r)
                ST_IDLE:   state_nx_s = hold_full_s ? ST_START : ST_IDLE;
                ST_START:  state_nx_s = ST_DATA;
                ST_DATA: begin
                    if (bit_idx_r == BIT_LAST) begin
                        state_nx_s = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: state_nx_s = ST_STOP;
                ST_STOP: begin
                    if (last_stop_s) begin
                        state_nx_s = hold_full_s ? ST_START : ST_IDLE;
                    end else begin
                        state_nx_s = ST_STOP;
                    end
                end
                default:   state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Per-state datapath updates: line level, shift register and counters.
    always_comb begin
        load_s        = 1'b0;
        tx_nx_s       = tx_r;
        shift_nx_s    = shift_r;
        bit_idx_nx_s  = bit_idx_r;
        stop_cnt_nx_s = stop_cnt_r;
        if (baud_tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (hold_full_s) begin
                        load_s     = 1'b1;
                        shift_nx_s = hold_r;
                        tx_nx_s    = 1'b0;
                    end else begin
                        tx_nx_s    = 1'b1;
                    end
                end
                ST_START: begin
                    tx_nx_s      = shift_r[0];
                    bit_idx_nx_s = {BIT_W{1'b0}};
                end
                ST_DATA: begin
                    if (bit_idx_r == BIT_LAST) begin
                        if (HAS_PARITY) begin
                            tx_nx_s       = parity_r;
                        end else begin
                            tx_nx_s       = 1'b1;
                            stop_cnt_nx_s = {STOP_W{1'b0}};
                        end
                    end else begin
                        // Shifting right keeps the next data bit at index 1.
                        tx_nx_s      = shift_r[1];
                        shift_nx_s   = shift_r >> 1;
                        bit_idx_nx_s = bit_idx_r + BIT_ONE;
                    end
                end
                ST_PARITY: begin
                    tx_nx_s       = 1'b1;
                    stop_cnt_nx_s = {STOP_W{1'b0}};
                end
                ST_STOP: begin
                    if (last_stop_s) begin
                        if (hold_full_s) begin
                            load_s     = 1'b1;
                            shift_nx_s = hold_r;
                            tx_nx_s    = 1'b0;
                        end else begin
                            tx_nx_s    = 1'b1;
                        end
                    end else begin
                        stop_cnt_nx_s = stop_cnt_r + STOP_ONE;
                    end
                end
                default: begin
                    tx_nx_s = 1'b1;
                end
            endcase
        end else begin
            tx_nx_s = tx_r;
        end
    end

    // Datapath registers and baud edge detector.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s_d_r  <= 1'b0;
            tx_r       <= 1'b1;
            shift_r    <= {DATA_BITS{1'b0}};
            parity_r   <= 1'b0;
            bit_idx_r  <= {BIT_W{1'b0}};
            stop_cnt_r <= {STOP_W{1'b0}};
        end else begin
            clk_s_d_r  <= clk_s;
            tx_r       <= tx_nx_s;
            shift_r    <= shift_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            stop_cnt_r <= stop_cnt_nx_s;
            if (load_s) begin
                parity_r <= parity_f(hold_r, ODD_PARITY);
            end else begin
                parity_r <= parity_r;
            end
        end
    end

    // Holding register: accept empties, load by the FSM refills tx_ready.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            hold_r     <= {DATA_BITS{1'b0}};
            tx_ready_r <= 1'b1;
        end else if (tx_valid && tx_ready_r) begin
            hold_r     <= tx_data;
            tx_ready_r <= 1'b0;
        end else if (load_s) begin
            hold_r     <= hold_r;
            tx_ready_r <= 1'b1;
        end else begin
            hold_r     <= hold_r;
            tx_ready_r <= tx_ready_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three configurations driven from one baud divider,
// frames predicted into a scoreboard and matched bit by bit at mid-bit sample points.
module tb_uart_tx_serializer;

    logic       clk_100 = 1'b0;
    logic       rst_n   = 1'b1;
    logic       clk_s   = 1'b0;
    int         div_cnt = 0;
    logic [7:0] data_a [3];
    logic [2:0] valid_v;
    logic [2:0] tx_v;
    logic [2:0] rdy_v;
    logic [2:0] busy_v;

    always #5 clk_100 = ~clk_100;

    uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_100(clk_100), .rst_n(rst_n), .clk_s(clk_s), .tx_data(data_a[0]),
        .tx_valid(valid_v[0]), .tx_ready(rdy_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk_100(clk_100), .rst_n(rst_n), .clk_s(clk_s), .tx_data(data_a[1]),
        .tx_valid(valid_v[1]), .tx_ready(rdy_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
    uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk_100(clk_100), .rst_n(rst_n), .clk_s(clk_s), .tx_data(data_a[2]),
        .tx_valid(valid_v[2]), .tx_ready(rdy_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));

    typedef struct {
        int          id;
        logic [15:0] bits;
        int          len;
    } frame_t;

    frame_t sb_q[$];
    frame_t mcur [3];
    int     mpos [3];
    int     mgap [3];
    int     mlastgap [3];
    int     mdone [3];
    int     exp_done [3];
    bit     mon_en = 1'b0;
    int     n_cmp  = 0;
    int     n_err  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t build(input int id, input logic [7:0] d);
        frame_t f;
        int     n;
        int     par;
        int     stops;
        par   = (id == 0) ? 0 : ((id == 1) ? 1 : 2);
        stops = (id == 1) ? 2 : 1;
        f.id   = id;
        f.bits = 16'h0000;
        n      = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (par != 0) begin
            f.bits[n] = (^d) ^ (par == 2);
            n++;
        end
        for (int s = 0; s < stops; s++) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        return f;
    endfunction

    task automatic mon_sample(input int id);
        int idx;
        if (mpos[id] < 0) begin
            if (tx_v[id] == 1'b0) begin
                idx = -1;
                foreach (sb_q[i]) if (idx < 0 && sb_q[i].id == id) idx = i;
                if (idx < 0) begin
                    check($sformatf("d%0d_unexpected_frame", id), 32'(tx_v[id]), 32'd1);
                end else begin
                    mcur[id] = sb_q[idx];
                    sb_q.delete(idx);
                    check($sformatf("d%0d_start_bit", id), 32'(tx_v[id]), 32'(mcur[id].bits[0]));
                    mpos[id]     = 1;
                    mlastgap[id] = mgap[id];
                    mgap[id]     = 0;
                end
            end else begin
                mgap[id]++;
            end
        end else begin
            check($sformatf("d%0d_bit%0d", id, mpos[id]), 32'(tx_v[id]),
                  32'(mcur[id].bits[mpos[id]]));
            mpos[id]++;
            if (mpos[id] >= mcur[id].len) begin
                mpos[id] = -1;
                mdone[id]++;
            end
        end
    endtask

    // Baud divider (num_clk = 4) and mid-bit line monitor.
    always @(negedge clk_100) begin
        div_cnt = (div_cnt + 1) % 8;
        if (div_cnt == 0 && mon_en) begin
            for (int id = 0; id < 3; id++) mon_sample(id);
        end
        clk_s = (div_cnt >= 4);
    end

    task automatic send(input int id, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk_100);
        data_a[id]  = d;
        valid_v[id] = 1'b1;
        for (int k = 0; k < 400 && !ok; k++) begin
            if (rdy_v[id]) begin
                @(posedge clk_100);
                #1;
                ok = 1'b1;
                sb_q.push_back(build(id, d));
                exp_done[id]++;
                check($sformatf("d%0d_ready_drop", id), 32'(rdy_v[id]), 32'd0);
            end else begin
                @(negedge clk_100);
            end
        end
        if (!ok) check($sformatf("d%0d_accept_timeout", id), 32'(ok), 32'd1);
    endtask

    task automatic drop_valid(input int id);
        @(negedge clk_100);
        valid_v[id] = 1'b0;
    endtask

    task automatic wait_done(input int id);
        for (int k = 0; k < 3000 && mdone[id] < exp_done[id]; k++) begin
            @(negedge clk_100);
            #1;
        end
        check($sformatf("d%0d_frames_done", id), 32'(mdone[id]), 32'(exp_done[id]));
    endtask

    initial begin
        valid_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            data_a[i]   = 8'h00;
            mpos[i]     = -1;
            mgap[i]     = 0;
            mlastgap[i] = -1;
            mdone[i]    = 0;
            exp_done[i] = 0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d_rst_tx", i), 32'(tx_v[i]), 32'd1);
            check($sformatf("d%0d_rst_ready", i), 32'(rdy_v[i]), 32'd1);
            check($sformatf("d%0d_rst_busy", i), 32'(busy_v[i]), 32'd0);
        end
        repeat (4) @(negedge clk_100);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single frame 0xA5: ready returns with the load, busy ends with the stop bit.
        send(0, 8'hA5);
        drop_valid(0);
        for (int k = 0; k < 40 && tx_v[0] !== 1'b0; k++) begin
            @(posedge clk_100);
            #1;
        end
        check("d0_tx_start", 32'(tx_v[0]), 32'd0);
        check("d0_ready_after_load", 32'(rdy_v[0]), 32'd1);
        check("d0_busy_in_frame", 32'(busy_v[0]), 32'd1);
        wait_done(0);
        repeat (3) @(negedge clk_100);
        check("d0_busy_in_stop", 32'(busy_v[0]), 32'd1);
        repeat (3) @(negedge clk_100);
        check("d0_busy_after_stop", 32'(busy_v[0]), 32'd0);
        check("d0_tx_idle", 32'(tx_v[0]), 32'd1);

        // Back-to-back 0x00 then 0xFF with valid held high.
        send(0, 8'h00);
        send(0, 8'hFF);
        check("d0_accept_while_busy", 32'(busy_v[0]), 32'd1);
        drop_valid(0);
        wait_done(0);
        check("d0_b2b_gap", 32'(mlastgap[0]), 32'd0);

        // Even parity with two stop bits, odd parity with one.
        send(1, 8'h07);
        drop_valid(1);
        send(2, 8'h07);
        drop_valid(2);
        send(1, 8'hC3);
        send(1, 8'h3C);
        drop_valid(1);
        wait_done(1);
        wait_done(2);
        check("d1_b2b_gap", 32'(mlastgap[1]), 32'd0);

        // Valid pulsed while the holding register is full is ignored.
        send(0, 8'h81);
        send(0, 8'h42);
        drop_valid(0);
        check("d0_ready_low_before_pulse", 32'(rdy_v[0]), 32'd0);
        data_a[0]  = 8'h55;
        valid_v[0] = 1'b1;
        @(negedge clk_100);
        valid_v[0] = 1'b0;
        wait_done(0);
        repeat (200) @(negedge clk_100);
        check("d0_no_extra_frame", 32'(mdone[0]), 32'(exp_done[0]));

        // Reset during data bit 3 aborts the frame immediately.
        send(0, 8'h12);
        drop_valid(0);
        for (int k = 0; k < 400 && mpos[0] != 5; k++) begin
            @(negedge clk_100);
            #1;
        end
        check("d0_reached_bit3", 32'(mpos[0]), 32'd5);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("d0_midrst_tx", 32'(tx_v[0]), 32'd1);
        check("d0_midrst_busy", 32'(busy_v[0]), 32'd0);
        check("d0_midrst_ready", 32'(rdy_v[0]), 32'd1);
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            mpos[i]     = -1;
            mgap[i]     = 0;
            exp_done[i] = mdone[i];
        end
        repeat (3) @(negedge clk_100);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        send(0, 8'h3C);
        drop_valid(0);
        wait_done(0);

        // Twenty ticks with nothing offered.
        for (int t = 0; t < 20; t++) begin
            repeat (8) @(negedge clk_100);
            check($sformatf("d0_idle_tx_t%0d", t), 32'(tx_v[0]), 32'd1);
            check($sformatf("d0_idle_busy_t%0d", t), 32'(busy_v[0]), 32'd0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d_monitor_idle", i), 32'(mpos[i]), 32'hFFFF_FFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter directly downstream of the baud clock divider.
- Consumes the divider's square-wave baud clock `clk_s` (one bit period per `clk_s` rising edge, 9600 baud at 100 MHz) and serialises parallel bytes onto the `tx` line, LSB first.
- One-word holding register plus shift register, so the core supplies back-to-back frames with no idle gap.
- Everything runs in the `clk_100` domain; `clk_s` is sampled as data, never used as a clock.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame, legal 1..2.

Ports:
- clk_100  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- clk_s  input  1  baud square wave from the clock divider, synchronous to `clk_100`
- tx_data  input  DATA_BITS  byte to send
- tx_valid  input  1  `tx_data` is valid
- tx_ready  output  1  holding register empty; word accepted when `tx_valid && tx_ready`
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress

Behaviour:
- Reset is asynchronous and active-low; one clock `clk_100`.
- While `rst_n` = 0: `tx` = 1, `tx_ready` = 1, `busy` = 0, holding register empty, state IDLE, bit/stop counters 0, `clk_s_d` = 0.
- Reset mid-frame aborts the frame immediately: `tx` returns high and any pending word is discarded.
- Baud tick:
  - `clk_s_d` is `clk_s` registered each `clk_100`.
  - `baud_tick = clk_s & ~clk_s_d`, a one-cycle pulse per `clk_s` rising edge.
  - All `tx` transitions occur on the `clk_100` edge at which `baud_tick` = 1, so each bit lasts exactly one `clk_s` period.
- Holding register:
  - On `tx_valid && tx_ready`, latch `tx_data`; `tx_ready` goes 0 the next cycle.
  - When the FSM loads the shift register from the holding register, `tx_ready` returns to 1 the next cycle.
  - No accept and load conflict can occur in one cycle, since `tx_ready` = 0 while the holding register is full.
  - `tx_data` is don't-care when not accepted.
- FSM states: IDLE, START, DATA, PARITY, STOP. `busy` = (state != IDLE). Transitions occur only on `baud_tick`:
  - IDLE: if holding register full, load shift register, `tx` <= 0, go to START. Otherwise stay, `tx` = 1.
  - START: `tx` <= `shift[0]`, `bit_idx` <= 0, go to DATA.
  - DATA: if `bit_idx` == DATA_BITS-1:
    - PARITY != 0: `tx` <= parity bit, go to PARITY.
    - PARITY = 0: `tx` <= 1, `stop_cnt` <= 0, go to STOP.
  - DATA, otherwise: `bit_idx` += 1, `tx` <= `shift[bit_idx+1]`.
  - PARITY: `tx` <= 1, `stop_cnt` <= 0, go to STOP.
  - STOP, `stop_cnt` < STOP_BITS-1: `stop_cnt` += 1.
  - STOP, final stop bit ends: if holding register full, load it, `tx` <= 0, go to START (zero-gap back-to-back). Otherwise go to IDLE, `tx` stays 1.
- Parity:
  - Even: XOR of the DATA_BITS data bits.
  - Odd: the inverse of that XOR.
  - Computed from the shift-register contents at load.
- Frame length is 1 + DATA_BITS + (PARITY != 0) + STOP_BITS tick periods.
- Start latency: a word accepted while IDLE starts at the next `baud_tick`, so the wait is 1 to 2×`num_clk` cycles.
- `baud_tick` with IDLE and empty holding register: no effect.
- `tx_valid` held with `tx_ready` = 0: no effect; the upstream side must hold the data until accepted.
- Illegal parameter values: elaboration error via a generate-time check.
- Counters are sized with `$clog2`; `bit_idx` never exceeds DATA_BITS-1.

Test Plan:
- Setup: divider `num_clk` = 4 (tick every 8 `clk_100` cycles), defaults.
  - Send 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
  - `busy` falls at the end of the stop bit; `tx_ready` high again 1 cycle after load.
- Back-to-back: offer 0x00 then 0xFF with `tx_valid` held high.
  - Second word accepted while the first is shifting.
  - Its start bit begins exactly at the end of the first stop bit; no idle gap.
- PARITY = 1, send 0x07 → parity bit 1.
- PARITY = 2, send 0x07 → parity bit 0.
- STOP_BITS = 2 → two high bit periods before the next start bit.
- Reset mid-frame: assert `rst_n` = 0 during data bit 3.
  - Within the same cycle `tx` = 1, `busy` = 0, `tx_ready` = 1.
  - After release, a new word 0x3C transmits correctly.
- Idle with ticks: no `tx_valid` for 20 ticks → `tx` stays 1, `busy` stays 0.
- `tx_valid` pulsed while `tx_ready` = 0 → word ignored; only accepted words appear on `tx`.
